uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART between the RN41 Bluetooth module pins and the wireless protocol block.
- Receive path: 16x oversampling with majority-free mid-bit sampling. Emits a one-cycle `received` strobe with `rx_byte`, or a one-cycle `recv_error`.
- Transmit path: serialises `tx_byte` when `transmit` is strobed.
- RX and TX run independently on one clock domain.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- DIV, CLK_HZ/(BAUD*16) (integer floor, >=1), clocks per oversample tick. BIT_CLKS = 16*DIV clocks per bit.

Ports:
- clk  input  1  master clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line from RN41 TX pin; asynchronous, idle high.
- tx  output  1  serial line to RN41 RX pin; idle high.
- transmit  input  1  one-cycle strobe: send tx_byte.
- tx_byte  input  8  byte to send; sampled only on an accepted strobe.
- received  output  1  one-cycle strobe: rx_byte holds a new valid byte.
- rx_byte  output  8  last good received byte; held until the next good byte.
- is_receiving  output  1  high while the RX FSM is not in RX_IDLE.
- is_transmitting  output  1  high while the TX FSM is not in TX_IDLE.
- recv_error  output  1  one-cycle strobe: framing error (stop bit sampled 0).

Behaviour:
- Reset values: tx=1, received=0, rx_byte=0, recv_error=0, is_receiving=0, is_transmitting=0. Both FSMs go to IDLE, all counters 0, rx synchroniser flops = 1. Reset mid-frame aborts immediately; no strobe is emitted for the aborted frame.
- Input sync: rx passes through 2 flops (rx_s). All RX decisions use rx_s only.
- Tick generator: free-running counter 0..DIV-1. rx_tick is high for one clock when the counter = DIV-1.
- RX FSM, counters advance only on rx_tick:
  - RX_IDLE: rx_s=0 on a tick -> RX_START, tick count = 0.
  - RX_START: after 8 ticks, sample rx_s. If 1 -> false start, back to RX_IDLE, no strobe. If 0 -> RX_DATA, bit index 0.
  - RX_DATA: every 16 ticks, sample rx_s into shift[index], LSB first. After index 7 -> RX_STOP.
  - RX_STOP: after 16 ticks, sample rx_s.
    - If 1: rx_byte <= shift, received=1 for exactly one clock, -> RX_IDLE.
    - If 0: recv_error=1 for one clock, rx_byte unchanged, -> RX_BREAK.
  - RX_BREAK: wait until rx_s=1 on a tick -> RX_IDLE. Prevents re-triggering on a held-low line or break condition.
  - received and recv_error are never high in the same cycle.
- TX FSM, counts raw clocks with a bit timer of BIT_CLKS:
  - TX_IDLE: transmit=1 latches tx_byte, -> TX_START. tx=0 and is_transmitting=1 from the next clock.
  - TX_START holds 1 bit time.
  - TX_DATA holds 8 bit times, LSB first.
  - TX_STOP holds tx=1 for 1 bit time, -> TX_IDLE. is_transmitting falls on the clock after the stop bit completes.
  - Frame length = 10*BIT_CLKS clocks exactly.
- transmit while is_transmitting=1 (any state other than TX_IDLE, including the final stop cycle) is ignored. No queueing; the in-flight byte is unaffected.
- Full duplex: a simultaneous RX frame and TX frame must not interact. transmit may arrive in the same cycle as received.
- Width rule: the bit timer must hold BIT_CLKS-1. Size it as $clog2(16*DIV).

Test Plan:
- Set DIV=1 (BIT_CLKS=16) for all scenarios below.
- RX good frame: drive 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop=1), 16 clocks/bit.
  -> exactly one received pulse within 16 clocks after stop-bit mid-point; rx_byte=0xA5; recv_error=0; is_receiving back to 0.
- RX framing error: drive 0x3C with stop bit 0, then hold rx low 40 clocks, then high.
  -> one recv_error pulse, no received pulse, rx_byte keeps its prior value 0xA5; is_receiving stays 1 until rx returns high, then 0.
- RX glitch: pulse rx low for 4 clocks from idle.
  -> no received, no recv_error; is_receiving returns 0 within 12 clocks.
- TX frame: strobe transmit with tx_byte=0x06.
  -> tx=0 from next clock for 16 clocks, then bits 0,1,1,0,0,0,0,0 at 16 clocks each, then 16 clocks high. is_transmitting high for exactly 160 clocks.
- TX busy drop: strobe 0x01, then strobe 0xFF at clock 50 and at the last busy clock.
  -> line carries only 0x01; after idle, a new strobe of 0xFF is sent correctly.
- Reset mid-operation: assert rst at clock 70 of an RX frame and a concurrent TX frame.
  -> next clock tx=1, both busy flags 0, no strobes; a subsequent clean 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_transceiver.sv
// -----------------------------------------------------------------------------
// uart_transceiver
//
// Full-duplex 8N1 UART between the RN41 Bluetooth module and the wireless
// protocol block. The receiver oversamples at 16x and takes one sample near
// the middle of each bit. The transmitter serialises one byte per strobe. The
// two directions share only the clock and reset.
//
// Ports
//   clk             in   master clock, all logic on posedge
//   rst             in   synchronous active-high reset
//   rx              in   serial line from RN41 TX pin (async, idle high)
//   tx              out  serial line to RN41 RX pin (idle high)
//   transmit        in   one-cycle strobe: send tx_byte (ignored while busy)
//   tx_byte  [7:0]  in   byte to send, captured on an accepted strobe
//   received        out  one-cycle strobe: rx_byte holds a new byte
//   rx_byte  [7:0]  out  last good received byte
//   is_receiving    out  RX FSM not idle
//   is_transmitting out  TX FSM not idle
//   recv_error      out  one-cycle strobe: stop bit sampled low
// -----------------------------------------------------------------------------
module uart_transceiver #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DIV    = ((CLK_HZ / (BAUD * 16)) < 1) ? 1 : (CLK_HZ / (BAUD * 16))
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);

  localparam int BIT_CLKS = 16 * DIV;
  localparam int TW       = $clog2(16 * DIV);
  localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] TICK_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CLKS - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  // Two-flop synchroniser on the asynchronous line.
  logic            rx_meta_q;
  logic            rx_s_q;

  logic [DW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            rx_tick;

  rx_state_t       rx_state_q, rx_state_d;
  logic [3:0]      rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            received_q, received_d;
  logic            recv_error_q, recv_error_d;

  tx_state_t       tx_state_q, tx_state_d;
  logic [TW-1:0]   tx_timer_q, tx_timer_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_q, tx_d;

  // State register: control and output flops (reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      tick_cnt_q   <= '0;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_byte_q    <= '0;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_timer_q   <= '0;
      tx_idx_q     <= '0;
      tx_q         <= 1'b1;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      tick_cnt_q   <= tick_cnt_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_byte_q    <= rx_byte_d;
      received_q   <= received_d;
      recv_error_q <= recv_error_d;
      tx_state_q   <= tx_state_d;
      tx_timer_q   <= tx_timer_d;
      tx_idx_q     <= tx_idx_d;
      tx_q         <= tx_d;
    end
  end

  // Data-only shift registers: contents are don't-care until the FSMs use them.
  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    tx_data_q  <= tx_data_d;
  end

  // Oversample tick generator.
  always_comb begin
    rx_tick    = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = rx_tick ? '0 : tick_cnt_q + DW'(1);
  end

  // RX next-state logic. All sampling decisions happen only on rx_tick.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_byte_d    = rx_byte_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;
    if (rx_tick) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s_q) begin
            rx_state_d = RX_START;
            rx_cnt_d   = '0;
          end
        end
        RX_START: begin
          // Eighth tick lands mid start bit; a high line here was a glitch.
          if (rx_cnt_q == 4'd7) begin
            rx_cnt_d   = '0;
            rx_idx_d   = '0;
            rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == 4'd15) begin
            rx_cnt_d             = '0;
            rx_shift_d[rx_idx_q] = rx_s_q;
            if (rx_idx_q == 3'd7) begin
              rx_state_d = RX_STOP;
            end else begin
              rx_idx_d = rx_idx_q + 3'd1;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == 4'd15) begin
            rx_cnt_d = '0;
            if (rx_s_q) begin
              rx_byte_d  = rx_shift_q;
              received_d = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
              recv_error_d = 1'b1;
              rx_state_d   = RX_BREAK;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
        RX_BREAK: begin
          // Hold off until the line returns high so a held-low line does not
          // look like a stream of start bits.
          if (rx_s_q) begin
            rx_state_d = RX_IDLE;
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // TX next-state logic. Bit timing counts raw clocks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q;
    tx_idx_d   = tx_idx_q;
    tx_data_d  = tx_data_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (transmit) begin
          tx_data_d  = tx_byte;
          tx_timer_d = '0;
          tx_idx_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      TX_DATA: begin
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
          end
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      TX_STOP: begin
        if (tx_timer_q == BIT_LAST) begin
          tx_timer_d = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_timer_d = tx_timer_q + TW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Line level is registered from the next state so the pin never glitches.
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_data_d[tx_idx_d];
      default:  tx_d = 1'b1;
    endcase
  end

  // Outputs.
  always_comb begin
    tx              = tx_q;
    received        = received_q;
    rx_byte         = rx_byte_q;
    recv_error      = recv_error_q;
    is_receiving    = (rx_state_q != RX_IDLE);
    is_transmitting = (tx_state_q != TX_IDLE);
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// -----------------------------------------------------------------------------
// tb_uart_transceiver
//
// Directed bench for uart_transceiver with DIV=1 (16 clocks per bit).
// Inputs change 1 time unit after each rising edge; outputs are read at the
// same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_transceiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       tx;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       received;
  logic [7:0] rx_byte;
  logic       is_receiving;
  logic       is_transmitting;
  logic       recv_error;

  int total = 0;
  int bad   = 0;

  int cyc     = 0;
  int n_rcv   = 0;
  int n_err   = 0;
  int n_both  = 0;
  int rcv_cyc = 0;

  uart_transceiver #(.CLK_HZ(16), .BAUD(1), .DIV(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .tx              (tx),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .received        (received),
    .rx_byte         (rx_byte),
    .is_receiving    (is_receiving),
    .is_transmitting (is_transmitting),
    .recv_error      (recv_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (received) begin
      n_rcv   <= n_rcv + 1;
      rcv_cyc <= cyc;
    end
    if (recv_error) n_err <= n_err + 1;
    if (received && recv_error) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_bit(input logic v);
    rx = v;
    repeat (16) step();
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
  endtask

  // Strobe b, then check every clock of the 160-clock frame. At offsets d1/d2
  // a one-clock strobe of 0xFF is attempted and must be ignored.
  task automatic tx_send(input logic [7:0] b, input int d1, input int d2);
    logic [9:0] fr;
    fr       = {1'b1, b, 1'b0};
    tx_byte  = b;
    transmit = 1'b1;
    step();
    transmit = 1'b0;
    for (int j = 0; j < 160; j++) begin
      chk("tx_line", tx, fr[j / 16]);
      chk("tx_busy", is_transmitting, 1);
      if (j == d1 || j == d2) begin
        transmit = 1'b1;
        tx_byte  = 8'hFF;
      end else begin
        transmit = 1'b0;
      end
      step();
    end
    transmit = 1'b0;
    chk("tx_done_busy", is_transmitting, 0);
    chk("tx_done_line", tx, 1);
  endtask

  initial begin
    int t0;
    int r0;
    int e0;
    logic [9:0] rfr;

    rst      = 1'b1;
    rx       = 1'b1;
    transmit = 1'b0;
    tx_byte  = 8'h00;
    repeat (3) step();

    // Reset state
    chk("rst_tx", tx, 1);
    chk("rst_received", received, 0);
    chk("rst_rx_byte", rx_byte, 8'h00);
    chk("rst_recv_error", recv_error, 0);
    chk("rst_is_receiving", is_receiving, 0);
    chk("rst_is_transmitting", is_transmitting, 0);
    rst = 1'b0;
    repeat (4) step();

    // RX good frame 0xA5
    r0 = n_rcv;
    e0 = n_err;
    t0 = cyc;
    rx_frame(8'hA5, 1'b1);
    repeat (4) step();
    chk("rx_good_count", n_rcv - r0, 1);
    chk("rx_good_err", n_err - e0, 0);
    chk("rx_good_byte", rx_byte, 8'hA5);
    chk("rx_good_timing", ((rcv_cyc - t0) >= 152) && ((rcv_cyc - t0) <= 168), 1);
    chk("rx_good_idle", is_receiving, 0);

    // RX framing error 0x3C, line then held low
    r0 = n_rcv;
    e0 = n_err;
    rx_frame(8'h3C, 1'b0);
    repeat (40) step();
    chk("rx_ferr_err", n_err - e0, 1);
    chk("rx_ferr_rcv", n_rcv - r0, 0);
    chk("rx_ferr_byte", rx_byte, 8'hA5);
    chk("rx_ferr_busy_low", is_receiving, 1);
    rx = 1'b1;
    repeat (6) step();
    chk("rx_ferr_idle", is_receiving, 0);

    // RX glitch: 4 clocks low
    r0 = n_rcv;
    e0 = n_err;
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    chk("rx_glitch_start", is_receiving, 1);
    repeat (12) step();
    chk("rx_glitch_idle", is_receiving, 0);
    chk("rx_glitch_rcv", n_rcv - r0, 0);
    chk("rx_glitch_err", n_err - e0, 0);

    // TX frame 0x06
    tx_send(8'h06, -1, -1);
    repeat (3) step();

    // TX busy drop: 0x01 with strobes at clock 50 and the last busy clock
    tx_send(8'h01, 50, 159);
    repeat (5) step();
    chk("tx_drop_idle", is_transmitting, 0);
    tx_send(8'hFF, -1, -1);
    repeat (3) step();

    // Reset at clock 70 of concurrent RX (0xC3) and TX (0x55) frames
    r0      = n_rcv;
    e0      = n_err;
    rfr     = {1'b1, 8'hC3, 1'b0};
    tx_byte = 8'h55;
    for (int c = 0; c < 70; c++) begin
      rx       = rfr[c / 16];
      transmit = (c == 0);
      step();
    end
    transmit = 1'b0;
    chk("mid_rx_busy", is_receiving, 1);
    chk("mid_tx_busy", is_transmitting, 1);
    rst = 1'b1;
    rx  = 1'b1;
    step();
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_rx_busy", is_receiving, 0);
    chk("mid_rst_tx_busy", is_transmitting, 0);
    chk("mid_rst_received", received, 0);
    chk("mid_rst_err", recv_error, 0);
    chk("mid_rst_rx_byte", rx_byte, 8'h00);
    rst = 1'b0;
    repeat (200) step();
    chk("mid_rst_no_rcv", n_rcv - r0, 0);
    chk("mid_rst_no_err", n_err - e0, 0);
    chk("mid_rst_tx_line", tx, 1);

    rx_frame(8'h5A, 1'b1);
    repeat (4) step();
    chk("post_rst_count", n_rcv - r0, 1);
    chk("post_rst_byte", rx_byte, 8'h5A);
    chk("post_rst_err", n_err - e0, 0);
    chk("never_both", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
